// File: rtl/arbitrate_pkg.sv
// +--------------------------------------------------------------------------+
// | arbitrate_pkg: shared state encoding and stb/rdy/dat handshake helpers   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package arbitrate_pkg;

  localparam int         STATE_W = 1;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] BUSY    = 1'b1;

  // A stream beat moves on any rising edge where the producer's stb and the
  // consumer's rdy are both high; the producer holds stb/dat until then.
  function automatic logic handshake(input logic stb, input logic rdy);
    return stb & rdy;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbitrate_prioritize.sv
// +--------------------------------------------------------------------------+
// | prioritize: rotating-priority picker, first set req at ptr, ptr+1, ...  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module prioritize #(
  parameter int ARGC = 2,
  parameter int SELW = $clog2(ARGC)
) (
  input  logic [ARGC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] w_j;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = '0;
    w_j = '0;
    for (int k = ARGC - 1; k >= 0; k--) begin
      w_j = SELW'((int'(ptr) + k) % ARGC);
      if (req[w_j]) begin
        idx = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arbitrate.sv
// +--------------------------------------------------------------------------+
// | arbitrate: round-robin merge of ARGC stb/rdy byte streams, PKTL-beat lock |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module arbitrate
  import arbitrate_pkg::*;
#(
  parameter int ARGW = 8,
  parameter int ARGC = 2,
  parameter int PKTL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ARGC-1:0]         arg_stb,
  input  logic [ARGC*ARGW-1:0]    arg_dat,
  output logic [ARGC-1:0]         arg_rdy,
  output logic                    out_stb,
  output logic [ARGW-1:0]         out_dat,
  output logic [$clog2(ARGC)-1:0] out_sel,
  input  logic                    out_rdy
);

  localparam int              SELW   = $clog2(ARGC);
  localparam int              CNTW   = (PKTL > 1) ? $clog2(PKTL) : 1;
  localparam logic [CNTW-1:0] c_LAST = CNTW'(PKTL - 1);

  logic [STATE_W-1:0] r_state;
  logic [SELW-1:0]    r_ptr;
  logic [SELW-1:0]    r_g;
  logic [CNTW-1:0]    r_cnt;

  logic               w_any;
  logic [SELW-1:0]    w_idx;
  logic               w_open;
  logic               w_xfer;
  logic [ARGW-1:0]    w_dat;

  prioritize #(
    .ARGC (ARGC),
    .SELW (SELW)
  ) u_prioritize (
    .req (arg_stb),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // The granted input may push whenever the output register is empty or
  // draining this edge; this path is combinational from out_rdy.
  assign w_open = (r_state == BUSY) && (!out_stb || out_rdy);

  generate
    for (genvar i = 0; i < ARGC; i++) begin : g_rdy
      assign arg_rdy[i] = w_open && (r_g == SELW'(i));
    end
  endgenerate

  assign w_xfer = handshake(arg_stb[r_g], w_open);
  assign w_dat  = arg_dat[r_g*ARGW +: ARGW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_cnt   <= '0;
      out_stb <= 1'b0;
      out_dat <= '0;
      out_sel <= '0;
    end else begin
      if (w_xfer) begin
        out_stb <= 1'b1;
        out_dat <= w_dat;
        out_sel <= r_g;
      end else if (out_rdy) begin
        out_stb <= 1'b0;
      end

      if (r_state == IDLE) begin
        if (w_any) begin
          r_g     <= w_idx;
          r_cnt   <= '0;
          r_state <= BUSY;
        end
      end else if (w_xfer) begin
        if (r_cnt == c_LAST) begin
          r_cnt   <= '0;
          r_state <= IDLE;
          r_ptr   <= (r_g == SELW'(ARGC - 1)) ? '0 : r_g + SELW'(1);
        end else begin
          r_cnt <= r_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbitrate.sv
// +--------------------------------------------------------------------------+
// | tb_arbitrate: directed checks on a 2x2 arbiter, random soak on a 3x1 one |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_arbitrate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Directed instance: ARGC=2, PKTL=2
  logic        a_rst = 1'b1;
  logic [1:0]  a_stb = '0;
  logic [15:0] a_dat = '0;
  logic [1:0]  a_rdy;
  logic        a_ostb;
  logic [7:0]  a_odat;
  logic [0:0]  a_osel;
  logic        a_ordy = 1'b1;

  // Soak instance: ARGC=3, PKTL=1
  logic        b_rst = 1'b1;
  logic [2:0]  b_stb = '0;
  logic [23:0] b_dat = '0;
  logic [2:0]  b_rdy;
  logic        b_ostb;
  logic [7:0]  b_odat;
  logic [1:0]  b_osel;
  logic        b_ordy = 1'b1;

  arbitrate #(.ARGW(8), .ARGC(2), .PKTL(2)) dut_a (
    .clk(clk), .rst(a_rst), .arg_stb(a_stb), .arg_dat(a_dat), .arg_rdy(a_rdy),
    .out_stb(a_ostb), .out_dat(a_odat), .out_sel(a_osel), .out_rdy(a_ordy)
  );

  arbitrate #(.ARGW(8), .ARGC(3), .PKTL(1)) dut_b (
    .clk(clk), .rst(b_rst), .arg_stb(b_stb), .arg_dat(b_dat), .arg_rdy(b_rdy),
    .out_stb(b_ostb), .out_dat(b_odat), .out_sel(b_osel), .out_rdy(b_ordy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed-bench producer queues and output log
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] olog[$];
  int         ocyc[$];
  logic [1:0] en = '0;
  logic [1:0] rdy_or;
  int         cyc = 0;
  int         first_ostb = -1;
  logic       last_ostb;
  logic [7:0] last_odat;
  logic [0:0] last_osel;
  logic [1:0] last_rdy;

  // One cycle starting at a negedge: drive, settle, observe, cross posedge.
  task automatic cycle_a();
    logic [1:0] ix;
    a_stb[0] = en[0] && (q0.size() > 0);
    a_stb[1] = en[1] && (q1.size() > 0);
    a_dat[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    a_dat[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    #1;
    last_ostb = a_ostb;
    last_odat = a_odat;
    last_osel = a_osel;
    last_rdy  = a_rdy;
    rdy_or    = rdy_or | a_rdy;
    chk("a_onehot", 32'($countones(a_rdy) <= 1), 32'd1);
    if (a_ostb && first_ostb < 0) first_ostb = cyc;
    ix = a_stb & a_rdy;
    if (a_ostb && a_ordy) begin
      olog.push_back({a_osel, a_odat});
      ocyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    if (ix[0]) void'(q0.pop_front());
    if (ix[1]) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic clear_log();
    olog.delete();
    ocyc.delete();
  endtask

  // Soak state: per-requester sequence numbers sent and received, wait counts
  int         tx[3];
  int         rx[3];
  int         waitc[3];
  logic [2:0] bx = '0;

  task automatic soak_cycle(input bit gen);
    int sel;
    for (int i = 0; i < 3; i++) begin
      if (bx[i]) begin
        tx[i]++;
        b_stb[i] = gen ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (!b_stb[i] && gen) begin
        b_stb[i] = 1'($urandom_range(0, 1));
      end
      b_dat[i*8 +: 8] = {2'(i), 6'(tx[i])};
    end
    b_ordy = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    chk("b_onehot", 32'($countones(b_rdy) <= 1), 32'd1);
    bx = b_stb & b_rdy;
    for (int i = 0; i < 3; i++) begin
      if (bx[i]) begin
        chk("b_wait", 32'(waitc[i] <= 2), 32'd1);
        waitc[i] = 0;
      end else if (b_stb[i]) begin
        waitc[i] += $countones(bx);
      end
    end
    if (b_ostb && b_ordy) begin
      sel = int'(b_osel);
      chk("b_sel_range", 32'(sel < 3), 32'd1);
      if (sel < 3) begin
        chk("b_order", 32'(b_odat), 32'({2'(sel), 6'(rx[sel])}));
        rx[sel]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [8:0] exp2 [8] = '{9'h010, 9'h011, 9'h120, 9'h121, 9'h012, 9'h013, 9'h122, 9'h123};
  int stb_cyc;
  int guard;

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_stb", 32'(a_ostb), 32'd0);
    chk("rst_out_dat", 32'(a_odat), 32'd0);
    chk("rst_out_sel", 32'(a_osel), 32'd0);
    chk("rst_arg_rdy", 32'(a_rdy), 32'd0);
    @(negedge clk);
    a_rst = 1'b0;

    // Single requester on input 1
    a_ordy = 1'b1;
    q1 = '{8'hA5, 8'h5A};
    en = 2'b10;
    first_ostb = -1;
    stb_cyc = cyc;
    clear_log();
    repeat (6) cycle_a();
    chk("single_cnt", 32'(olog.size()), 32'd2);
    chk("single_0", 32'(olog[0]), 32'h1A5);
    chk("single_1", 32'(olog[1]), 32'h15A);
    chk("single_lat", 32'(first_ostb - stb_cyc), 32'd2);

    // Contention, both inputs always valid
    q0 = '{8'h10, 8'h11, 8'h12, 8'h13};
    q1 = '{8'h20, 8'h21, 8'h22, 8'h23};
    en = 2'b11;
    clear_log();
    repeat (16) cycle_a();
    chk("cont_cnt", 32'(olog.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("cont_order", 32'(olog[k]), 32'(exp2[k]));
    chk("cont_inpkt", 32'(ocyc[1] - ocyc[0]), 32'd1);
    chk("cont_gap", 32'(ocyc[2] - ocyc[1]), 32'd2);

    // Packet lock: input 0 stalls mid-packet while input 1 keeps requesting
    q0 = '{8'h10, 8'h11};
    q1 = '{8'h30, 8'h31};
    en = 2'b11;
    clear_log();
    guard = 0;
    while (q0.size() != 1 && guard < 10) begin cycle_a(); guard++; end
    chk("lock_start", 32'(q0.size()), 32'd1);
    en = 2'b10;
    rdy_or = '0;
    repeat (5) cycle_a();
    chk("lock_rdy1", 32'(rdy_or[1]), 32'd0);
    chk("lock_rdy0", 32'(rdy_or[0]), 32'd1);
    en = 2'b11;
    repeat (10) cycle_a();
    chk("lock_cnt", 32'(olog.size()), 32'd4);
    chk("lock_0", 32'(olog[0]), 32'h010);
    chk("lock_1", 32'(olog[1]), 32'h011);
    chk("lock_2", 32'(olog[2]), 32'h130);
    chk("lock_3", 32'(olog[3]), 32'h131);

    // Backpressure mid-packet
    q0 = '{8'h40, 8'h41};
    q1 = '{8'h50, 8'h51};
    en = 2'b11;
    clear_log();
    guard = 0;
    while (q0.size() != 1 && guard < 10) begin cycle_a(); guard++; end
    chk("bp_start", 32'(q0.size()), 32'd1);
    a_ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle_a();
      chk("bp_stb", 32'(last_ostb), 32'd1);
      chk("bp_dat", 32'(last_odat), 32'h40);
      chk("bp_sel", 32'(last_osel), 32'd0);
      chk("bp_rdy", 32'(last_rdy), 32'd0);
    end
    chk("bp_held", 32'(q0.size()), 32'd1);
    a_ordy = 1'b1;
    repeat (10) cycle_a();
    chk("bp_cnt", 32'(olog.size()), 32'd4);
    chk("bp_0", 32'(olog[0]), 32'h040);
    chk("bp_1", 32'(olog[1]), 32'h041);
    chk("bp_2", 32'(olog[2]), 32'h150);
    chk("bp_3", 32'(olog[3]), 32'h151);

    // Reset after the first beat of input 0's packet
    q0 = '{8'h60, 8'h61};
    en = 2'b01;
    guard = 0;
    while (q0.size() != 1 && guard < 10) begin cycle_a(); guard++; end
    chk("rstmid_start", 32'(q0.size()), 32'd1);
    en = 2'b00;
    a_rst = 1'b1;
    cycle_a();
    #1;
    chk("rstmid_stb", 32'(a_ostb), 32'd0);
    chk("rstmid_rdy", 32'(a_rdy), 32'd0);
    chk("rstmid_sel", 32'(a_osel), 32'd0);
    a_rst = 1'b0;
    q0.delete();
    clear_log();
    q1 = '{8'h70};
    en = 2'b10;
    repeat (6) cycle_a();
    chk("rstmid_cnt", 32'(olog.size()), 32'd1);
    chk("rstmid_grant", 32'(olog[0]), 32'h170);

    // Random soak on the 3-input, 1-beat instance
    for (int i = 0; i < 3; i++) begin tx[i] = 0; rx[i] = 0; waitc[i] = 0; end
    b_rst = 1'b0;
    repeat (10000) soak_cycle(1'b1);
    repeat (20) soak_cycle(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("soak_sent_gt0", 32'(tx[i] > 0), 32'd1);
      chk("soak_count", 32'(rx[i]), 32'(tx[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbitrate.md
# arbitrate

Round-robin arbiter merging ARGC stb/rdy byte streams into one output stream with packet lock. A granted requester keeps the output for PKTL consecutive transfers. This keeps multi-beat words, such as the two unpacked bytes of a 16-bit product, contiguous. It lets several producers share one transmit resource, e.g. the product stream and a status/error byte stream feeding `transmit`.

## Interface
- ARGW, 8: data width of each input and the output, in bits
- ARGC, 2: number of requesters, ≥2
- PKTL, 2: transfers per grant (packet length), ≥1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- arg_stb  input  ARGC  per-requester data valid
- arg_dat  input  ARGC*ARGW  requester i occupies bits [i*ARGW +: ARGW]
- arg_rdy  output  ARGC  per-requester ready, at most one bit high
- out_stb  output  1  output data valid (registered)
- out_dat  output  ARGW  output data (registered)
- out_sel  output  $clog2(ARGC)  index of the requester whose beat is on out_dat (registered)
- out_rdy  input  1  downstream ready

## Operation
- **Transfer rule.** A transfer occurs on any edge where stb and rdy are both high. A producer must hold stb and dat stable until the transfer.
- **States.**
  - IDLE: no grant.
  - BUSY: grant g is held with beat counter cnt in 0..PKTL-1.
- **IDLE.**
  - If any arg_stb is high, pick the first high index searching ptr, ptr+1, … mod ARGC.
  - On that edge: set g to the picked index, cnt=0, go BUSY.
  - If no arg_stb is high, stay in IDLE.
  - All arg_rdy are 0 in IDLE.
- **BUSY.**
  - arg_rdy[g] = !out_stb || out_rdy. This is combinational from out_rdy; the other arg_rdy bits are 0.
  - On a transfer from g:
    - out_dat ← arg_dat[g], out_sel ← g, out_stb ← 1.
    - cnt increments.
  - On the PKTL-th transfer: ptr ← (g+1) mod ARGC and the state returns to IDLE.
- **Output register.**
  - out_stb clears after an output transfer unless a new input transfer occurs on the same edge.
  - out_dat and out_sel hold their values while out_stb is high and out_rdy is low.
- **Packet lock.**
  - If arg_stb[g] drops mid-packet, the grant is kept and the arbiter waits indefinitely.
  - No other requester is served until g completes PKTL beats.
- **Fairness.** ptr moves past the last-served requester. A continuously requesting input therefore waits at most ARGC-1 packets.
- **PKTL=1.** Degenerates to per-beat round-robin.
- **Reset.** Applies in any state, including mid-packet.
  - Next state: IDLE, ptr=0, cnt=0, g=0.
  - Outputs: out_stb=0, out_dat=0, out_sel=0, all arg_rdy=0.
  - Partial packets are dropped; no recovery is attempted.

## Timing
- **Arbitration latency.** 1 cycle: the stb seen in IDLE gives arg_rdy high on the next cycle.
- **Data latency.** 1 cycle: out_stb rises the cycle after the input transfer.
- **Idle to first output.** out_stb rises 2 cycles after arg_stb rises, provided out_rdy is high.
- **Throughput inside a packet.** 1 beat/cycle when out_rdy is held high.
- **Packet gap.** One IDLE cycle for re-arbitration, so sustained throughput is PKTL/(PKTL+1).
- **Backpressure.**
  - When out_stb=1 and out_rdy=0, arg_rdy[g] is 0 in the same cycle.
  - No beat is lost or duplicated.
- **Simultaneous events.**
  - Input and output transfer on the same edge: the new beat replaces the old one; out_stb stays 1.
  - rst high together with a transfer: rst wins.

## Structure
- **Shared package.**
  - State encoding constants IDLE/BUSY go in the shared package.
  - The handshake interface description for stb/rdy/dat streams is reused by arbitrate, demultiplex and unpack.
- **Sub-module `prioritize`.**
  - Combinational rotating-priority picker.
  - Inputs: req[ARGC], ptr. Outputs: any, idx.
  - It is reused by future multi-requester blocks.
  - arbitrate instantiates one `prioritize` and contains the state register, counter and output register.

## Test plan
- **Single requester.** ARGC=2, PKTL=2, only input 1 sends 0xA5 then 0x5A, out_rdy=1.
  - Output is 0xA5 then 0x5A with out_sel=1 on both.
  - out_stb first rises 2 cycles after arg_stb[1].
- **Contention and interleave.** Both inputs always valid: input 0 sends 0x10,0x11,0x12,0x13; input 1 sends 0x20,0x21,0x22,0x23.
  - Output order is 10,11,20,21,12,13,22,23.
  - One idle cycle between packets.
- **Packet lock.** Input 0 sends 0x10, then drops stb for 5 cycles while input 1 stays valid.
  - arg_rdy[1] stays 0 throughout.
  - Output is 0x10, then 0x11 when it arrives, then input 1's data.
- **Backpressure.** Hold out_rdy=0 for 4 cycles mid-packet.
  - out_dat and out_sel stay stable and arg_rdy=0 for those cycles.
  - No loss or duplication after release; a scoreboard compares per-input order.
- **Reset mid-packet.** Assert rst after the first beat of input 0's packet.
  - The next cycle has out_stb=0, arg_rdy=0 and out_sel=0.
  - After release, a request from input 1 alone is granted (ptr=0 search skips idle input 0).
- **Random soak.** ARGC=3, PKTL=1, random stb and out_rdy for 10k cycles.
  - At most one arg_rdy bit is high in every cycle.
  - Each requester's byte sequence is preserved.
  - Wait for any requester is ≤ ARGC-1 grants.
